// File: rtl/mips_pkg.sv
// Shared MIPS32 constants: opcodes, funct codes, NOP word, field positions, fetch-controller states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_pkg;

   // Primary opcodes (instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes (instruction[5:0])
   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;

   // sll $0,$0,0 -- the canonical MIPS NOP, returned for bad fetches
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // Field bit positions (LSB of each field) and widths
   localparam int OPC_LSB   = 26;
   localparam int OPC_W     = 6;
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RD_LSB    = 11;
   localparam int REG_W     = 5;
   localparam int IMM_LSB   = 0;
   localparam int IMM_W     = 16;
   localparam int JADDR_LSB = 0;
   localparam int JADDR_W   = 26;
   localparam int FUNCT_LSB = 0;
   localparam int FUNCT_W   = 6;

   // Controller state: loader owns the memory, or core fetches from it
   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } imem_state_t;

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Loader + fetch bundle between the program loader / core (master) and the instruction memory (slave).
// Latency: wires only.
// Backpressure: ld_ready gates loader writes; fetch side has none (one word per enabled cycle).
interface instr_mem_loadable_if #(
   parameter int MEM_WIDTH = 32,
   parameter int MEM_DEPTH = 1024,
   parameter int ADDR_SIZE = 32
);
   localparam int CNT_W = $clog2(MEM_DEPTH) + 1;

   // loader channel
   logic                 ld_valid;
   logic                 ld_ready;
   logic [ADDR_SIZE-1:0] ld_addr;
   logic [MEM_WIDTH-1:0] ld_data;
   logic                 ld_done;
   logic                 ld_err;
   logic [CNT_W-1:0]     load_count;
   logic                 run_mode;

   // fetch channel
   logic                 fetch_en;
   logic [ADDR_SIZE-1:0] Instruction_addr;
   logic                 instr_valid;
   logic                 instr_fault;
   logic [MEM_WIDTH-1:0] instruction;

   // decoded fields of the registered instruction
   logic [5:0]           opcode_bits;
   logic [4:0]           rd_addr1;
   logic [4:0]           rd_addr2;
   logic [4:0]           wr_addr;
   logic [15:0]          branch_16bit_addr;
   logic [25:0]          jump_26bit_addr;
   logic [5:0]           function_bits;

   modport master (
      output ld_valid, ld_addr, ld_data, ld_done, fetch_en, Instruction_addr,
      input  ld_ready, ld_err, load_count, run_mode,
      input  instr_valid, instr_fault, instruction,
      input  opcode_bits, rd_addr1, rd_addr2, wr_addr,
      input  branch_16bit_addr, jump_26bit_addr, function_bits
   );

   modport slave (
      input  ld_valid, ld_addr, ld_data, ld_done, fetch_en, Instruction_addr,
      output ld_ready, ld_err, load_count, run_mode,
      output instr_valid, instr_fault, instruction,
      output opcode_bits, rd_addr1, rd_addr2, wr_addr,
      output branch_16bit_addr, jump_26bit_addr, function_bits
   );
endinterface

// File: rtl/instr_field_decode.sv
// Combinational MIPS32 field slicer: one word in, seven field outputs.
// Latency: 0 cycles (pure wiring).
// Backpressure: none.
module instr_field_decode
   import mips_pkg::*;
(
   input  logic [31:0] word,
   output logic [5:0]  opcode_bits,
   output logic [4:0]  rd_addr1,
   output logic [4:0]  rd_addr2,
   output logic [4:0]  wr_addr,
   output logic [15:0] branch_16bit_addr,
   output logic [25:0] jump_26bit_addr,
   output logic [5:0]  function_bits
);
   assign opcode_bits       = word[OPC_LSB   +: OPC_W];
   assign rd_addr1          = word[RS_LSB    +: REG_W];
   assign rd_addr2          = word[RT_LSB    +: REG_W];
   assign wr_addr           = word[RD_LSB    +: REG_W];
   assign branch_16bit_addr = word[IMM_LSB   +: IMM_W];
   assign jump_26bit_addr   = word[JADDR_LSB +: JADDR_W];
   assign function_bits     = word[FUNCT_LSB +: FUNCT_W];
endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: LOAD phase takes loader writes, RUN phase serves registered fetches with field decode.
// Latency: fetch word appears 1 cycle after the fetch_en edge; loader writes land on the accepting edge.
// Backpressure: ld_ready low in RUN (loader ignored); fetch path never stalls, bad addresses return NOP + fault.
module instr_mem_loadable
   import mips_pkg::*;
#(
   parameter int MEM_WIDTH = 32,
   parameter int MEM_DEPTH = 1024,
   parameter int ADDR_SIZE = 32
) (
   input logic                clk,
   input logic                rst,
   instr_mem_loadable_if.slave bus
);
   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam int IW    = ADDR_SIZE - 2;

   localparam logic [IW-1:0]    DEPTH_IDX = IW'(MEM_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(MEM_DEPTH);

   logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

   imem_state_t          state;
   logic                 ld_ready_q;
   logic                 run_mode_q;
   logic                 ld_err_q;
   logic [CNT_W-1:0]     load_count_q;
   logic                 instr_valid_q;
   logic                 instr_fault_q;
   logic [MEM_WIDTH-1:0] instr_q;

   logic [IW-1:0] ld_idx;
   logic [IW-1:0] fe_idx;
   logic          ld_bad;
   logic          fe_bad;
   logic          wr_en;

   // Word index is the byte address without its two alignment bits.
   assign ld_idx = bus.ld_addr[ADDR_SIZE-1:2];
   assign fe_idx = bus.Instruction_addr[ADDR_SIZE-1:2];
   assign ld_bad = (bus.ld_addr[1:0] != 2'b00) || (ld_idx >= DEPTH_IDX);
   assign fe_bad = (bus.Instruction_addr[1:0] != 2'b00) || (fe_idx >= DEPTH_IDX);
   assign wr_en  = (state == ST_LOAD) && bus.ld_valid && !ld_bad;

   // Program store: no reset so contents survive rst; a write coinciding with rst is dropped whole.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem[ld_idx[IDX_W-1:0]] <= bus.ld_data;
      end
   end

   // Controller FSM with all outputs registered: load bookkeeping in LOAD, fetch pipeline in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_LOAD;
         ld_ready_q    <= 1'b1;
         run_mode_q    <= 1'b0;
         ld_err_q      <= 1'b0;
         load_count_q  <= '0;
         instr_valid_q <= 1'b0;
         instr_fault_q <= 1'b0;
         instr_q       <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               instr_valid_q <= 1'b0;
               ld_err_q      <= bus.ld_valid && ld_bad;
               if (wr_en && (load_count_q != DEPTH_CNT)) begin
                  load_count_q <= load_count_q + 1'b1;
               end
               // a same-cycle write has already been accepted above
               if (bus.ld_done) begin
                  state      <= ST_RUN;
                  ld_ready_q <= 1'b0;
                  run_mode_q <= 1'b1;
               end
            end
            ST_RUN: begin
               ld_err_q      <= 1'b0;
               instr_valid_q <= bus.fetch_en;
               if (bus.fetch_en) begin
                  if (fe_bad) begin
                     instr_q       <= MEM_WIDTH'(NOP_WORD);
                     instr_fault_q <= 1'b1;
                  end else begin
                     instr_q       <= mem[fe_idx[IDX_W-1:0]];
                     instr_fault_q <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   assign bus.ld_ready    = ld_ready_q;
   assign bus.run_mode    = run_mode_q;
   assign bus.ld_err      = ld_err_q;
   assign bus.load_count  = load_count_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr_fault = instr_fault_q;
   assign bus.instruction = instr_q;

   instr_field_decode u_decode (
      .word              (instr_q),
      .opcode_bits       (bus.opcode_bits),
      .rd_addr1          (bus.rd_addr1),
      .rd_addr2          (bus.rd_addr2),
      .wr_addr           (bus.wr_addr),
      .branch_16bit_addr (bus.branch_16bit_addr),
      .jump_26bit_addr   (bus.jump_26bit_addr),
      .function_bits     (bus.function_bits)
   );
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: directed program load/fetch plus randomized load and fetch traffic.
// Latency: expects fetched words exactly one edge after the request.
// Backpressure: loader drives only while the model says LOAD; RUN-phase loader traffic must be ignored.
module tb_instr_mem_loadable;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   instr_mem_loadable_if #(.MEM_WIDTH(32), .MEM_DEPTH(DEPTH), .ADDR_SIZE(32)) bus ();

   instr_mem_loadable #(.MEM_WIDTH(32), .MEM_DEPTH(DEPTH), .ADDR_SIZE(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          cyc;
      logic [31:0] instr;
      logic        fault;
   } fexp_t;

   typedef struct {
      logic [CW-1:0] cnt;
      logic          run;
      logic          err;
   } sexp_t;

   fexp_t fq[$];
   sexp_t sq[$];

   // reference model: word-addressed program image and phase flag
   logic [31:0] ref_mem [DEPTH];
   bit          is_written [DEPTH];
   int          written_q[$];
   bit          m_run = 1'b0;
   int          m_cnt = 0;

   int vec  = 0;
   int miss = 0;

   logic [31:0] last_i = '0;
   logic        last_f = 1'b0;
   bit          armed  = 1'b0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endfunction

   function automatic bit is_bad(logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
   endfunction

   // drive one cycle's inputs and record what the design must show after the next edge
   task automatic apply(input logic lv, input logic [31:0] la, input logic [31:0] ldt,
                        input logic dn, input logic fe, input logic [31:0] fa);
      sexp_t s;
      fexp_t f;
      int    idx;
      bus.ld_valid         = lv;
      bus.ld_addr          = la;
      bus.ld_data          = ldt;
      bus.ld_done          = dn;
      bus.fetch_en         = fe;
      bus.Instruction_addr = fa;
      s.err = 1'b0;
      if (!m_run) begin
         if (lv) begin
            if (is_bad(la)) begin
               s.err = 1'b1;
            end else begin
               idx = int'(la >> 2);
               ref_mem[idx] = ldt;
               if (!is_written[idx]) begin
                  is_written[idx] = 1'b1;
                  written_q.push_back(idx);
               end
               if (m_cnt < DEPTH) m_cnt++;
            end
         end
         if (dn) m_run = 1'b1;
      end else if (fe) begin
         f.cyc   = cyc + 1;
         f.fault = is_bad(fa);
         f.instr = f.fault ? 32'h0 : ref_mem[int'(fa >> 2)];
         fq.push_back(f);
      end
      s.cnt = CW'(m_cnt);
      s.run = m_run;
      sq.push_back(s);
      armed = 1'b1;
   endtask

   task automatic cycle(input logic lv, input logic [31:0] la, input logic [31:0] ldt,
                        input logic dn, input logic fe, input logic [31:0] fa);
      @(negedge clk);
      apply(lv, la, ldt, dn, fe, fa);
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      cycle(1'b1, a, d, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic fetch(input logic [31:0] a);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, a);
   endtask

   task automatic idle();
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_instruction"}, 64'(bus.instruction), 64'h0);
      chk({tag, "_instr_valid"}, 64'(bus.instr_valid), 64'h0);
      chk({tag, "_instr_fault"}, 64'(bus.instr_fault), 64'h0);
      chk({tag, "_ld_err"},      64'(bus.ld_err),      64'h0);
      chk({tag, "_load_count"},  64'(bus.load_count),  64'h0);
      chk({tag, "_run_mode"},    64'(bus.run_mode),    64'h0);
      chk({tag, "_ld_ready"},    64'(bus.ld_ready),    64'h1);
   endtask

   // hit rst while a fetch is set up for the coming edge; outputs must clear without a clock
   task automatic reset_mid(input logic [31:0] fa);
      @(negedge clk);
      bus.ld_valid         = 1'b0;
      bus.ld_done          = 1'b0;
      bus.fetch_en         = 1'b1;
      bus.Instruction_addr = fa;
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      fq.delete();
      sq.delete();
      m_run  = 1'b0;
      m_cnt  = 0;
      last_i = '0;
      last_f = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   // scoreboard monitor: status every cycle, fetch results whenever instr_valid is shown
   always @(posedge clk) begin
      #1;
      if (!rst && armed) begin
         if (sq.size() == 0) begin
            chk("status_underflow", 64'(sq.size()), 64'h1);
         end else begin
            sexp_t s;
            s = sq.pop_front();
            chk("load_count", 64'(bus.load_count), 64'(s.cnt));
            chk("run_mode",   64'(bus.run_mode),   64'(s.run));
            chk("ld_ready",   64'(bus.ld_ready),   64'(!s.run));
            chk("ld_err",     64'(bus.ld_err),     64'(s.err));
         end
         if (bus.instr_valid) begin
            if (fq.size() == 0) begin
               chk("spurious_instr_valid", 64'(bus.instr_valid), 64'h0);
            end else begin
               fexp_t f;
               f = fq.pop_front();
               chk("fetch_latency", 64'(cyc), 64'(f.cyc));
               chk("instruction",   64'(bus.instruction), 64'(f.instr));
               chk("instr_fault",   64'(bus.instr_fault), 64'(f.fault));
               chk("opcode_bits",   64'(bus.opcode_bits),       64'(f.instr[31:26]));
               chk("rd_addr1",      64'(bus.rd_addr1),          64'(f.instr[25:21]));
               chk("rd_addr2",      64'(bus.rd_addr2),          64'(f.instr[20:16]));
               chk("wr_addr",       64'(bus.wr_addr),           64'(f.instr[15:11]));
               chk("branch16",      64'(bus.branch_16bit_addr), 64'(f.instr[15:0]));
               chk("jump26",        64'(bus.jump_26bit_addr),   64'(f.instr[25:0]));
               chk("function_bits", 64'(bus.function_bits),     64'(f.instr[5:0]));
               if (f.instr == 32'h0109_8820) begin
                  chk("add_opcode", 64'(bus.opcode_bits),   64'd0);
                  chk("add_rs",     64'(bus.rd_addr1),      64'd8);
                  chk("add_rt",     64'(bus.rd_addr2),      64'd9);
                  chk("add_rd",     64'(bus.wr_addr),       64'd17);
                  chk("add_funct",  64'(bus.function_bits), 64'h20);
               end
               last_i = f.instr;
               last_f = f.fault;
            end
         end else begin
            chk("hold_instruction", 64'(bus.instruction), 64'(last_i));
            chk("hold_fault",       64'(bus.instr_fault), 64'(last_f));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int          idx;

      bus.ld_valid         = 1'b0;
      bus.ld_addr          = '0;
      bus.ld_data          = '0;
      bus.ld_done          = 1'b0;
      bus.fetch_en         = 1'b0;
      bus.Instruction_addr = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i]    = '0;
         is_written[i] = 1'b0;
      end

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      rst = 1'b0;
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

      // small program, then enter RUN
      load(32'h0, 32'h0109_8820);
      load(32'h4, 32'hAC11_0004);
      load(32'h8, 32'h8C0A_0004);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);

      // back-to-back fetches, bad addresses, fault recovery, hold
      fetch(32'h0);
      fetch(32'h4);
      fetch(32'h8);
      fetch(32'h6);
      fetch(32'(4 * DEPTH));
      fetch(32'h4);
      idle();
      idle();

      // RUN ignores the loader entirely
      cycle(1'b1, 32'h2, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 32'hC, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hC);

      // back to LOAD: bad loads, fetch while loading, write+done together
      reset_mid(32'h8);
      load(32'h2, 32'h1111_1111);
      load(32'(4 * DEPTH), 32'h2222_2222);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
      cycle(1'b1, 32'hC, 32'h014B_4022, 1'b1, 1'b0, 32'h0);
      fetch(32'hC);
      fetch(32'h0);
      idle();

      // memory survives reset
      reset_mid(32'h4);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      fetch(32'h0);
      idle();

      // randomized load phase (enough good writes to saturate load_count)
      reset_mid(32'h0);
      for (int n = 0; n < 60; n++) begin
         idx = int'($urandom_range(0, DEPTH - 1));
         case ($urandom_range(0, 7))
            0:       a = 32'(idx * 4) + 32'($urandom_range(1, 3));
            1:       a = 32'($urandom_range(DEPTH, 64 * DEPTH)) << 2;
            default: a = 32'(idx * 4);
         endcase
         d = $urandom;
         cycle(($urandom_range(0, 4) != 0), a, d, 1'b0, $urandom_range(0, 1) == 1, 32'h0);
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);

      // randomized fetch phase with stray loader traffic
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 4))
            0: a = ($urandom_range(0, 1) == 1) ? (32'($urandom) | 32'h1)
                                               : (32'($urandom_range(DEPTH, 4096)) << 2);
            default: a = 32'(written_q[$urandom_range(0, written_q.size() - 1)] * 4);
         endcase
         cycle($urandom_range(0, 3) == 0, 32'($urandom_range(0, DEPTH - 1)) << 2, $urandom,
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, a);
      end

      idle();
      idle();
      idle();
      #2;
      chk("fetch_queue_drained", 64'(fq.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
